mem_bus_arbiter: RTL and testbench

- Shares the single main-memory block port between the instruction cache (read-only) and the data cache (read/write, write-back).
- Sits below both caches, above main memory.
- Requesters hold a request until their busywait drops; the arbiter serialises transactions, routes strobes and address/data, and generates per-requester busywait.
- Round-robin on simultaneous requests, so a fetch stream and a dcache writeback/refill burst cannot starve each other.

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/mem_bus_arbiter_rr_pick2.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM encodings,
// grant identifiers and default bus widths.
package mem_bus_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W  = 28;
   localparam int unsigned DEF_BLOCK_W = 128;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t IDLE    = 2'd0;
   localparam arb_state_t GRANT_I = 2'd1;
   localparam arb_state_t GRANT_D = 2'd2;

   // last_grant encoding
   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and memory-side block bus shared by the icache, dcache,
// arbiter and main memory.
interface mem_bus_arbiter_if
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned BLOCK_W = DEF_BLOCK_W
);

   logic               i_read;
   logic [ADDR_W-1:0]  i_address;
   logic [BLOCK_W-1:0] i_readdata;
   logic               i_busywait;

   logic               d_read;
   logic               d_write;
   logic [ADDR_W-1:0]  d_address;
   logic [BLOCK_W-1:0] d_writedata;
   logic [BLOCK_W-1:0] d_readdata;
   logic               d_busywait;

   logic               mem_read;
   logic               mem_write;
   logic [ADDR_W-1:0]  mem_address;
   logic [BLOCK_W-1:0] mem_writedata;
   logic [BLOCK_W-1:0] mem_readdata;
   logic               mem_busywait;

   // arbiter view
   modport master (
      input  i_read, i_address, d_read, d_write, d_address, d_writedata,
             mem_readdata, mem_busywait,
      output i_readdata, i_busywait, d_readdata, d_busywait,
             mem_read, mem_write, mem_address, mem_writedata
   );

   // caches + memory view
   modport slave (
      output i_read, i_address, d_read, d_write, d_address, d_writedata,
             mem_readdata, mem_busywait,
      input  i_readdata, i_busywait, d_readdata, d_busywait,
             mem_read, mem_write, mem_address, mem_writedata
   );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Combinational two-way picker: bit 0 = icache, bit 1 = dcache.
// On a tie, alternates against last_grant or always favours the dcache.
module rr_pick2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       round_robin,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (req == 2'b11) begin
         if (round_robin && (last_grant == GNT_D)) begin
            gnt = 2'b01;
         end else begin
            gnt = 2'b10;
         end
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises icache reads and dcache reads/writebacks onto the single
// main-memory block port and generates per-requester busywait.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned BLOCK_W     = DEF_BLOCK_W,
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   mem_bus_arbiter_if.master    bus
);

   arb_state_t         state, state_nxt;
   logic               last_grant, last_grant_nxt;
   logic               wait_seen, wait_seen_nxt;
   logic               i_req, d_req, done;
   logic [1:0]         pick;
   logic [ADDR_W-1:0]  addr_mux;
   logic [BLOCK_W-1:0] wdata_mux;

   assign i_req = bus.i_read;
   assign d_req = bus.d_read | bus.d_write;

   // Memory may hold busywait low for a few cycles after the strobe, so
   // completion needs a busy phase to have been observed first.
   assign done = wait_seen & ~bus.mem_busywait;

   rr_pick2 u_pick (
      .req         ({d_req, i_req}),
      .last_grant  (last_grant),
      .round_robin (ROUND_ROBIN != 0),
      .gnt         (pick)
   );

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wait_seen_nxt  = wait_seen;
      unique case (state)
         IDLE: begin
            wait_seen_nxt = 1'b0;
            if (pick[0]) begin
               state_nxt      = GRANT_I;
               last_grant_nxt = GNT_I;
            end else if (pick[1]) begin
               state_nxt      = GRANT_D;
               last_grant_nxt = GNT_D;
            end
         end
         GRANT_I, GRANT_D: begin
            if (done) begin
               state_nxt     = IDLE;
               wait_seen_nxt = 1'b0;
            end else if (bus.mem_busywait) begin
               wait_seen_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            wait_seen_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GNT_D;
         wait_seen  <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         wait_seen  <= wait_seen_nxt;
      end
   end

   // Outputs are forced low while reset is high so they clear the same cycle.
   always_comb begin
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.i_busywait = 1'b0;
      bus.d_busywait = 1'b0;
      addr_mux       = '0;
      wdata_mux      = '0;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               bus.i_busywait = i_req;
               bus.d_busywait = d_req;
            end
            GRANT_I: begin
               bus.mem_read   = bus.i_read & ~done;
               addr_mux       = bus.i_address;
               bus.i_busywait = ~done;
               bus.d_busywait = d_req;
            end
            GRANT_D: begin
               // write wins when both strobes are up; the read is reissued later
               bus.mem_write  = bus.d_write & ~done;
               bus.mem_read   = bus.d_read & ~bus.d_write & ~done;
               addr_mux       = bus.d_address;
               wdata_mux      = bus.d_writedata;
               bus.d_busywait = ~done;
               bus.i_busywait = i_req;
            end
            default: begin
               bus.i_busywait = 1'b0;
               bus.d_busywait = 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_address   = addr_mux;
   assign bus.mem_writedata = wdata_mux;
   assign bus.i_readdata    = bus.mem_readdata;
   assign bus.d_readdata    = bus.mem_readdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a programmable-latency memory
// model; a second instance covers the fixed-priority mode.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int AW = 28;
   localparam int BW = 128;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   mem_bus_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();
   mem_bus_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus0 ();

   mem_bus_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .ROUND_ROBIN(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   mem_bus_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .ROUND_ROBIN(0)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0.master)
   );

   function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
      return {32'hDEADBEEF, 32'hCAFEF00D, 36'h0, a};
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- memory model (main instance) ----------------
   int          mem_delay = 0;
   int          mem_busy  = 2;
   int          m_ph, m_cnt;
   logic        m_rd;
   logic [AW-1:0] m_addr;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_ph <= 0; m_cnt <= 0; m_rd <= 1'b0; m_addr <= '0;
         bus.mem_busywait <= 1'b0;
         bus.mem_readdata <= '0;
      end else begin
         case (m_ph)
            0: if (bus.mem_read || bus.mem_write) begin
               m_addr <= bus.mem_address;
               m_rd   <= bus.mem_read;
               bus.mem_readdata <= '0;
               if (mem_delay == 0) begin
                  bus.mem_busywait <= 1'b1; m_cnt <= mem_busy; m_ph <= 2;
               end else begin
                  m_cnt <= mem_delay; m_ph <= 1;
               end
            end
            1: if (m_cnt == 1) begin
               bus.mem_busywait <= 1'b1; m_cnt <= mem_busy; m_ph <= 2;
            end else m_cnt <= m_cnt - 1;
            default: if (m_cnt == 1) begin
               bus.mem_busywait <= 1'b0; m_ph <= 0;
               if (m_rd) bus.mem_readdata <= blk(m_addr);
            end else m_cnt <= m_cnt - 1;
         endcase
      end
   end

   // ---------------- memory model (fixed-priority instance) ----------------
   int            m0_ph, m0_cnt;
   logic [AW-1:0] m0_addr;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m0_ph <= 0; m0_cnt <= 0; m0_addr <= '0;
         bus0.mem_busywait <= 1'b0;
         bus0.mem_readdata <= '0;
      end else if (m0_ph == 0) begin
         if (bus0.mem_read || bus0.mem_write) begin
            m0_addr <= bus0.mem_address; m0_ph <= 1; m0_cnt <= 2;
            bus0.mem_busywait <= 1'b1;
            bus0.mem_readdata <= '0;
         end
      end else if (m0_cnt == 1) begin
         bus0.mem_busywait <= 1'b0; m0_ph <= 0;
         bus0.mem_readdata <= blk(m0_addr);
      end else m0_cnt <= m0_cnt - 1;
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
   } mem_op_t;

   typedef struct packed {
      logic          who;   // 0 = icache, 1 = dcache
      logic          chk;
      logic [BW-1:0] data;
   } resp_t;

   mem_op_t exp_mem[$];
   resp_t   exp_resp[$];
   mem_op_t mon_op;
   resp_t   mon_rsp;
   logic    prev_strobe;

   always @(negedge clock) begin
      if (reset) begin
         prev_strobe <= 1'b0;
      end else begin
         if ((bus.mem_read || bus.mem_write) && !prev_strobe) begin
            if (exp_mem.size() == 0) begin
               check("unexpected_strobe", {bus.mem_read, bus.mem_write}, 2'b00);
            end else begin
               mon_op = exp_mem.pop_front();
               check("mem_read",      bus.mem_read,      mon_op.rd);
               check("mem_write",     bus.mem_write,     mon_op.wr);
               check("mem_address",   bus.mem_address,   mon_op.addr);
               check("mem_writedata", bus.mem_writedata, mon_op.data);
            end
         end
         prev_strobe <= bus.mem_read | bus.mem_write;

         if (bus.i_read && !bus.i_busywait) begin
            if (exp_resp.size() == 0) check("unexpected_i_done", 1'b1, 1'b0);
            else begin
               mon_rsp = exp_resp.pop_front();
               check("i_done_owner", 1'b0, mon_rsp.who);
               if (mon_rsp.chk) check("i_readdata", bus.i_readdata, mon_rsp.data);
            end
         end
         if ((bus.d_read || bus.d_write) && !bus.d_busywait) begin
            if (exp_resp.size() == 0) check("unexpected_d_done", 1'b1, 1'b0);
            else begin
               mon_rsp = exp_resp.pop_front();
               check("d_done_owner", 1'b1, mon_rsp.who);
               if (mon_rsp.chk) check("d_readdata", bus.d_readdata, mon_rsp.data);
            end
         end
      end
   end

   // ---------------- requesters ----------------
   // Called at posedge+1; exp_wait > 0 means the arbiter is idle and the
   // negedge count up to the completion cycle is known exactly.
   task automatic run_i(input logic [AW-1:0] a, input int exp_wait);
      int n = 0;
      bus.i_address = a;
      bus.i_read    = 1'b1;
      do begin
         @(negedge clock);
         n++;
         if (n == 1) check("i_stall_first", bus.i_busywait, 1'b1);
         if (exp_wait > 0 && n == 2) begin
            check("i_strobe_lat",  bus.mem_read,    1'b1);
            check("i_strobe_addr", bus.mem_address, a);
         end
      end while (bus.i_busywait && n < 100);
      check("i_complete", bus.i_busywait, 1'b0);
      if (exp_wait > 0) check("i_latency", n, exp_wait);
      @(posedge clock); #1;
      bus.i_read = 1'b0;
   endtask

   task automatic run_d(input logic [AW-1:0] a, input logic rd, input logic wr,
                        input logic [BW-1:0] wd, input int exp_wait);
      int n = 0;
      bus.d_address   = a;
      bus.d_writedata = wd;
      bus.d_read      = rd;
      bus.d_write     = wr;
      do begin
         @(negedge clock);
         n++;
         if (n == 1) check("d_stall_first", bus.d_busywait, 1'b1);
         if (exp_wait > 0 && rd && wr) check("rw_no_mem_read", bus.mem_read, 1'b0);
      end while (bus.d_busywait && n < 100);
      check("d_complete", bus.d_busywait, 1'b0);
      if (exp_wait > 0) check("d_latency", n, exp_wait);
      @(posedge clock); #1;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
   endtask

   localparam logic [BW-1:0] W1 = 128'h11112222_33334444_55556666_77778888;
   localparam logic [BW-1:0] W2 = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
   localparam logic [BW-1:0] W3 = 128'h01020304_05060708_090A0B0C_0D0E0F10;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [AW-1:0] da;
      bus.i_read = 1'b0; bus.i_address = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
      bus0.i_read = 1'b0; bus0.i_address = '0;
      bus0.d_read = 1'b0; bus0.d_write = 1'b0; bus0.d_address = '0; bus0.d_writedata = '0;

      // reset state
      repeat (2) @(negedge clock);
      check("reset_outputs", {bus.mem_read, bus.mem_write, bus.i_busywait, bus.d_busywait,
                              bus.mem_address, bus.mem_writedata}, '0);
      reset = 1'b0;
      @(posedge clock); #1;

      // first tie after reset: icache, then dcache writeback
      exp_mem.push_back('{1'b1, 1'b0, 28'h0000030, '0});
      exp_mem.push_back('{1'b0, 1'b1, 28'h0000040, W1});
      exp_resp.push_back('{1'b0, 1'b1, blk(28'h0000030)});
      exp_resp.push_back('{1'b1, 1'b0, '0});
      fork
         run_i(28'h0000030, -1);
         run_d(28'h0000040, 1'b0, 1'b1, W1, -1);
      join

      // next tie returns to the icache
      exp_mem.push_back('{1'b1, 1'b0, 28'h0000050, '0});
      exp_mem.push_back('{1'b1, 1'b0, 28'h0000060, '0});
      exp_resp.push_back('{1'b0, 1'b1, blk(28'h0000050)});
      exp_resp.push_back('{1'b1, 1'b1, blk(28'h0000060)});
      fork
         run_i(28'h0000050, -1);
         run_d(28'h0000060, 1'b1, 1'b0, '0, -1);
      join

      // solo icache read, memory busy 5 cycles
      mem_delay = 0; mem_busy = 5;
      exp_mem.push_back('{1'b1, 1'b0, 28'h0000010, '0});
      exp_resp.push_back('{1'b0, 1'b1, blk(28'h0000010)});
      run_i(28'h0000010, 8);

      // busywait raised one cycle late: no early completion
      mem_delay = 1; mem_busy = 2;
      exp_mem.push_back('{1'b1, 1'b0, 28'h0000020, '0});
      exp_resp.push_back('{1'b0, 1'b1, blk(28'h0000020)});
      run_i(28'h0000020, 6);

      // read and write together: only the write reaches memory
      mem_delay = 0; mem_busy = 2;
      exp_mem.push_back('{1'b0, 1'b1, 28'h00000A4, W2});
      exp_resp.push_back('{1'b1, 1'b0, '0});
      run_d(28'h00000A4, 1'b1, 1'b1, W2, 5);

      // async reset in the middle of a dcache write
      mem_busy = 10;
      exp_mem.push_back('{1'b0, 1'b1, 28'h0000070, W3});
      bus.d_address = 28'h0000070; bus.d_writedata = W3; bus.d_write = 1'b1;
      n = 0;
      while (!bus.mem_busywait && n < 50) begin @(negedge clock); n++; end
      check("rst_mid_busy", bus.mem_busywait, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("rst_mem_write",  bus.mem_write,  1'b0);
      check("rst_d_busywait", bus.d_busywait, 1'b0);
      bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
      @(posedge clock);
      @(negedge clock) reset = 1'b0;
      @(negedge clock);
      check("post_rst_outputs", {bus.mem_read, bus.mem_write, bus.i_busywait, bus.d_busywait,
                                 bus.mem_address, bus.mem_writedata}, '0);
      @(posedge clock); #1;

      // reset restores icache priority on the first tie
      mem_busy = 2;
      exp_mem.push_back('{1'b1, 1'b0, 28'h0000080, '0});
      exp_mem.push_back('{1'b1, 1'b0, 28'h0000090, '0});
      exp_resp.push_back('{1'b0, 1'b1, blk(28'h0000080)});
      exp_resp.push_back('{1'b1, 1'b1, blk(28'h0000090)});
      fork
         run_i(28'h0000080, -1);
         run_d(28'h0000090, 1'b1, 1'b0, '0, -1);
      join

      // fixed priority: dcache wins three back-to-back ties
      bus0.i_address = 28'h0000100; bus0.i_read = 1'b1;
      da = 28'h0000200;
      bus0.d_address = da; bus0.d_read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            @(negedge clock);
            n++;
            check("rr0_i_stalled", bus0.i_busywait, 1'b1);
            if (bus0.mem_read) check("rr0_mem_address", bus0.mem_address, da);
         end while (bus0.d_busywait && n < 50);
         check("rr0_d_complete", bus0.d_busywait, 1'b0);
         check("rr0_d_readdata", bus0.d_readdata, blk(da));
         @(posedge clock); #1;
         if (k < 2) begin
            da = da + 28'd1;
            bus0.d_address = da;
         end else begin
            bus0.d_read = 1'b0;
         end
      end
      n = 0;
      while (bus0.i_busywait && n < 50) begin @(negedge clock); n++; end
      check("rr0_i_complete", bus0.i_busywait, 1'b0);
      check("rr0_i_readdata", bus0.i_readdata, blk(28'h0000100));
      @(posedge clock); #1;
      bus0.i_read = 1'b0;

      repeat (3) @(negedge clock);
      check("mem_queue_empty",  exp_mem.size(),  0);
      check("resp_queue_empty", exp_resp.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
